// File: rtl/vliw_wb_stage.sv
// rtl/vliw_wb_stage.sv - parametrised VLIW writeback pipeline with conflict resolution and forwarding
//
// Purpose:
//   Carries per-slot (valid, rd, result) from the execute/memory slots through
//   DEPTH register stages. Stage DEPTH-1 drives the register-file write ports.
//   Same-bundle destination conflicts are resolved at capture (highest slot wins).
//   A combinational forwarding lookup searches every in-flight stage for decode.
//
// Ports:
//   clk, rst          core clock, asynchronous active-high reset
//   stall             hold every stage (flush ignored while stalled)
//   flush             kill the bundle being captured this cycle
//   ex_valid/rd/res   per-slot execute results, slot s at [s*W +: W]
//   wb_we/rd/data     register-file write ports from stage DEPTH-1
//   fwd_addr          per-port lookup addresses from decode
//   fwd_hit/fwd_data  per-port forwarding result (data 0 when no hit)
//   conflict          registered flag: last captured bundle had a same-rd conflict
//   conflict_cnt      saturating 16-bit count of captured conflicts
//                     (present only when WB_CONFLICT_CNT_EN is defined)
//
// Optional feature macro: WB_CONFLICT_CNT_EN

module vliw_wb_stage #(
  parameter int NUM_SLOTS  = 4,
  parameter int RD_W       = 7,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 2,
  parameter int NUM_RPORTS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [NUM_SLOTS-1:0]         ex_valid,
  input  logic [NUM_SLOTS*RD_W-1:0]    ex_rd,
  input  logic [NUM_SLOTS*DATA_W-1:0]  ex_res,
  output logic [NUM_SLOTS-1:0]         wb_we,
  output logic [NUM_SLOTS*RD_W-1:0]    wb_rd,
  output logic [NUM_SLOTS*DATA_W-1:0]  wb_data,
  input  logic [NUM_RPORTS*RD_W-1:0]   fwd_addr,
  output logic [NUM_RPORTS-1:0]        fwd_hit,
  output logic [NUM_RPORTS*DATA_W-1:0] fwd_data,
  output logic                         conflict
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [15:0]                  conflict_cnt
`endif
);

  // Stage registers; index 0 is the youngest stage.
  logic [DEPTH-1:0][NUM_SLOTS-1:0]        valid_q;
  logic [DEPTH-1:0][NUM_SLOTS*RD_W-1:0]   rd_q;
  logic [DEPTH-1:0][NUM_SLOTS*DATA_W-1:0] data_q;
  logic                                   conflict_q;

  // Next contents of stage 0.
  logic [NUM_SLOTS-1:0]        raw_valid;
  logic [NUM_SLOTS-1:0]        valid_d;
  logic [NUM_SLOTS*RD_W-1:0]   rd_d;
  logic [NUM_SLOTS*DATA_W-1:0] data_d;
  logic                        conflict_d;

  // Capture qualification and same-rd resolution. A slot is dropped when any
  // higher-index valid slot targets the same register, so the last writer in
  // program order survives. Dropped/invalid entries carry rd=0, data=0.
  always_comb begin
    raw_valid  = '0;
    valid_d    = '0;
    rd_d       = '0;
    data_d     = '0;
    conflict_d = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      raw_valid[s] = ex_valid[s] & ~flush & (ex_rd[s*RD_W +: RD_W] != '0);
    end
    valid_d = raw_valid;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      for (int j = i + 1; j < NUM_SLOTS; j++) begin
        if (raw_valid[i] && raw_valid[j] &&
            (ex_rd[i*RD_W +: RD_W] == ex_rd[j*RD_W +: RD_W])) begin
          valid_d[i] = 1'b0;
          conflict_d = 1'b1;
        end
      end
    end
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (valid_d[s]) begin
        rd_d[s*RD_W +: RD_W]     = ex_rd[s*RD_W +: RD_W];
        data_d[s*DATA_W +: DATA_W] = ex_res[s*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      rd_q       <= '0;
      data_q     <= '0;
      conflict_q <= 1'b0;
    end else if (!stall) begin
      valid_q[0] <= valid_d;
      rd_q[0]    <= rd_d;
      data_q[0]  <= data_d;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        rd_q[k]    <= rd_q[k-1];
        data_q[k]  <= data_q[k-1];
      end
      conflict_q <= conflict_d;
    end
  end

`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] cnt_q;

  // One increment per conflicting bundle regardless of how many pairs clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!stall && conflict_d && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign conflict_cnt = cnt_q;
`endif

  assign wb_we    = valid_q[DEPTH-1];
  assign wb_rd    = rd_q[DEPTH-1];
  assign wb_data  = data_q[DEPTH-1];
  assign conflict = conflict_q;

  // Forwarding: scan oldest stage to youngest and low slot to high, letting
  // later matches overwrite earlier ones, so stage 0 / highest slot wins.
  // The writeback stage is included to cover write-then-read in the same cycle.
  always_comb begin
    logic [RD_W-1:0] addr;
    addr     = '0;
    fwd_hit  = '0;
    fwd_data = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      addr = fwd_addr[p*RD_W +: RD_W];
      for (int k = DEPTH - 1; k >= 0; k--) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          if ((addr != '0) && valid_q[k][s] && (rd_q[k][s*RD_W +: RD_W] == addr)) begin
            fwd_hit[p]                   = 1'b1;
            fwd_data[p*DATA_W +: DATA_W] = data_q[k][s*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vliw_wb_stage.sv
// tb/tb_vliw_wb_stage.sv - scoreboard testbench for vliw_wb_stage

module tb_vliw_wb_stage;

  localparam int NS = 4;
  localparam int RW = 7;
  localparam int DW = 32;
  localparam int D  = 2;
  localparam int NP = 8;

  typedef struct packed {
    logic [NS-1:0]         v;
    logic [NS-1:0][RW-1:0] rd;
    logic [NS-1:0][DW-1:0] d;
    logic                  conf;
  } bundle_t;

  logic              clk;
  logic              rst;
  logic              stall;
  logic              flush;
  logic [NS-1:0]     ex_valid;
  logic [NS*RW-1:0]  ex_rd;
  logic [NS*DW-1:0]  ex_res;
  logic [NS-1:0]     wb_we;
  logic [NS*RW-1:0]  wb_rd;
  logic [NS*DW-1:0]  wb_data;
  logic [NP*RW-1:0]  fwd_addr;
  logic [NP-1:0]     fwd_hit;
  logic [NP*DW-1:0]  fwd_data;
  logic              conflict;
`ifdef WB_CONFLICT_CNT_EN
  logic [15:0]       conflict_cnt;
  int                exp_cnt;
`endif

  vliw_wb_stage #(
    .NUM_SLOTS(NS), .RD_W(RW), .DATA_W(DW), .DEPTH(D), .NUM_RPORTS(NP)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_res(ex_res),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .conflict(conflict)
`ifdef WB_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  bundle_t q[$];
  bundle_t cur;
  int cap_cnt;
  int pop_cnt;
  bit started;
  bit done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected captured bundle: a slot survives when it is a real write and no
  // later slot of the same bundle writes the same register.
  function automatic bundle_t resolve(input logic [NS-1:0] v, input logic [NS*RW-1:0] rd,
                                      input logic [NS*DW-1:0] res, input logic fl);
    bundle_t b;
    int owner[int];
    b = '0;
    for (int s = 0; s < NS; s++)
      if (v[s] && !fl && rd[s*RW +: RW] != 0) owner[int'(rd[s*RW +: RW])] = s;
    for (int s = 0; s < NS; s++) begin
      if (v[s] && !fl && rd[s*RW +: RW] != 0) begin
        if (owner[int'(rd[s*RW +: RW])] == s) begin
          b.v[s]  = 1'b1;
          b.rd[s] = rd[s*RW +: RW];
          b.d[s]  = res[s*DW +: DW];
        end else begin
          b.conf = 1'b1;
        end
      end
    end
    return b;
  endfunction

  // In flight = pending queue (youngest at the back) followed by the bundle
  // currently at the write ports.
  function automatic void fwd_model(input logic [RW-1:0] a, output logic h, output logic [DW-1:0] d);
    bundle_t b;
    h = 1'b0;
    d = '0;
    if (a == 0) return;
    for (int i = q.size(); i >= 0; i--) begin
      b = (i == q.size()) ? cur : q[i];
      if (i == q.size()) continue;
      for (int s = NS - 1; s >= 0; s--) begin
        if (b.v[s] && b.rd[s] == a) begin
          h = 1'b1;
          d = b.d[s];
          return;
        end
      end
    end
    for (int s = NS - 1; s >= 0; s--) begin
      if (cur.v[s] && cur.rd[s] == a) begin
        h = 1'b1;
        d = cur.d[s];
        return;
      end
    end
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < D - 1; i++) q.push_back('0);
    cur     = '0;
    pop_cnt = cap_cnt;
`ifdef WB_CONFLICT_CNT_EN
    exp_cnt = 0;
`endif
  endtask

  // Monitor: once per cycle, retire a bundle if a capture happened, then
  // compare every DUT output against the model.
  initial begin
    logic          h;
    logic [DW-1:0] d;
    logic          ec;
    wait (started);
    while (!done) begin
      @(negedge clk);
      if (pop_cnt != cap_cnt) begin
        cur = q.pop_front();
        pop_cnt++;
      end
      for (int s = 0; s < NS; s++) begin
        chk($sformatf("wb_we[%0d]", s), 64'(wb_we[s]), 64'(cur.v[s]));
        if (cur.v[s]) chk($sformatf("wb_rd[%0d]", s), 64'(wb_rd[s*RW +: RW]), 64'(cur.rd[s]));
        chk($sformatf("wb_data[%0d]", s), 64'(wb_data[s*DW +: DW]), 64'(cur.d[s]));
      end
      ec = (q.size() > 0) ? q[q.size()-1].conf : cur.conf;
      chk("conflict", 64'(conflict), 64'(ec));
      for (int p = 0; p < NP; p++) begin
        fwd_model(fwd_addr[p*RW +: RW], h, d);
        chk($sformatf("fwd_hit[%0d]", p), 64'(fwd_hit[p]), 64'(h));
        chk($sformatf("fwd_data[%0d]", p), 64'(fwd_data[p*DW +: DW]), 64'(d));
      end
`ifdef WB_CONFLICT_CNT_EN
      chk("conflict_cnt", 64'(conflict_cnt), 64'(exp_cnt));
`endif
    end
  end

  // One clock: inputs already driven; record the capture in the model.
  task automatic cycle();
    bundle_t b;
    @(posedge clk);
    if (!rst && !stall) begin
      b = resolve(ex_valid, ex_rd, ex_res, flush);
      q.push_back(b);
      cap_cnt++;
`ifdef WB_CONFLICT_CNT_EN
      if (b.conf && exp_cnt < 65535) exp_cnt++;
`endif
    end
    #1;
  endtask

  task automatic idle();
    ex_valid = '0;
    ex_rd    = '0;
    ex_res   = '0;
    flush    = 1'b0;
    stall    = 1'b0;
  endtask

  task automatic set_slot(input int s, input logic [RW-1:0] rd, input logic [DW-1:0] res);
    ex_valid[s]          = 1'b1;
    ex_rd[s*RW +: RW]    = rd;
    ex_res[s*DW +: DW]   = res;
  endtask

  task automatic all_fa(input logic [RW-1:0] a);
    for (int p = 0; p < NP; p++) fwd_addr[p*RW +: RW] = a;
  endtask

  task automatic rand_fa();
    for (int p = 0; p < NP; p++) fwd_addr[p*RW +: RW] = RW'($urandom_range(0, 12));
  endtask

  task automatic rand_bundle();
    for (int s = 0; s < NS; s++) begin
      ex_valid[s]        = ($urandom_range(0, 3) != 0);
      ex_rd[s*RW +: RW]  = RW'($urandom_range(0, 12));
      ex_res[s*DW +: DW] = $urandom;
    end
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_wb_we", 64'(wb_we), 64'(0));
    chk("rst_fwd_hit", 64'(fwd_hit), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cap_cnt = 0;
    pop_cnt = 0;
    started = 0;
    done    = 0;
    rst     = 1'b1;
    fwd_addr = '0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_wb_we", 64'(wb_we), 64'(0));
    chk("reset_conflict", 64'(conflict), 64'(0));
    started = 1;

    // basic pipeline
    idle(); all_fa(5);
    set_slot(1, 5, 32'hDEAD_BEEF);
    cycle();
    idle(); cycle(); cycle(); cycle();

    // stall hold
    idle(); set_slot(0, 3, 32'h33); set_slot(1, 7, 32'h77);
    fwd_addr[0 +: RW] = 3; fwd_addr[RW +: RW] = 7;
    cycle();
    for (int i = 0; i < 3; i++) begin
      rand_bundle();
      stall = 1'b1;
      cycle();
    end
    idle(); cycle(); cycle(); cycle();

    // flush and x0
    idle();
    for (int s = 0; s < NS; s++) set_slot(s, RW'(s + 1), DW'(s + 100));
    flush = 1'b1;
    for (int p = 0; p < NP; p++) fwd_addr[p*RW +: RW] = RW'(p % 5);
    cycle();
    idle(); set_slot(0, 0, 32'h1234); cycle();
    idle(); cycle(); cycle();

    // same-bundle conflict
    idle(); all_fa(9);
    set_slot(0, 9, 11); set_slot(2, 9, 22);
    cycle();
    idle(); cycle(); cycle(); cycle();

    // forward priority across stages and slots
    idle(); all_fa(6);
    set_slot(0, 6, 100); cycle();
    idle(); set_slot(0, 6, 200); set_slot(3, 6, 300); cycle();
    idle(); cycle(); cycle(); cycle();

    // async reset with stages full
    rand_bundle(); rand_fa(); cycle();
    rand_bundle(); set_slot(1, 4, 1); set_slot(3, 4, 2); cycle();
    all_fa(4);
    do_reset();
    idle(); set_slot(2, 8, 32'hCAFE); all_fa(8); cycle();
    idle(); cycle(); cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_bundle();
      rand_fa();
      stall = ($urandom_range(0, 4) == 0);
      flush = !stall && ($urandom_range(0, 9) == 0);
      cycle();
      if (i == 200) do_reset();
    end
    idle(); cycle(); cycle(); cycle();

    done = 1;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vliw_wb_stage.md
Name: vliw_wb_stage

Overview:
- Parametrised writeback pipeline for the VLIW core. Replaces the fixed 4-slot writeback register with N slots and a configurable pipeline depth.
- Carries per-slot destination, result and valid from the execute/memory slots through DEPTH register stages.
- Resolves same-bundle destination conflicts and drives register-file write ports.
- Provides a forwarding lookup over all in-flight stages for the decode stage.

Parameters:
- NUM_SLOTS, 4, number of issue slots per bundle
- RD_W, 7, destination register address width (int + float file)
- DATA_W, 32, result width
- DEPTH, 2, writeback pipeline stages (>=1); stage DEPTH-1 drives the register file
- NUM_RPORTS, 8, forwarding lookup ports

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  global stall; hold all stages
- flush  in  1  kill the bundle being captured this cycle
- ex_valid  in  NUM_SLOTS  per-slot result valid
- ex_rd  in  NUM_SLOTS*RD_W  per-slot destination, slot s at [s*RD_W +: RD_W]
- ex_res  in  NUM_SLOTS*DATA_W  per-slot result
- wb_we  out  NUM_SLOTS  register-file write enable per slot
- wb_rd  out  NUM_SLOTS*RD_W  write address per slot
- wb_data  out  NUM_SLOTS*DATA_W  write data per slot
- fwd_addr  in  NUM_RPORTS*RD_W  lookup addresses from decode
- fwd_hit  out  NUM_RPORTS  in-flight match found
- fwd_data  out  NUM_RPORTS*DATA_W  forwarded value (0 when no hit)
- conflict  out  1  registered pulse: captured bundle had a same-rd conflict

Behaviour:
- Reset (async): every stage valid=0, rd=0, data=0.
  - Outputs at reset: wb_we=0, wb_rd=0, wb_data=0, fwd_hit=0, fwd_data=0, conflict=0.
- Capture, on a clk edge with stall=0:
  - Stage 0 loads the ex_* inputs; stage k loads stage k-1 for k=1..DEPTH-1.
  - Per-slot captured valid = ex_valid[s] & !flush & (ex_rd[s]!=0). rd 0 is never written.
- Stall=1: all stages, including conflict, hold their value.
  - flush is ignored while stall=1. The branch unit only asserts flush on unstalled cycles.
- Conflict resolution at capture time:
  - If valid slots i<j share rd, only the highest-index slot keeps valid; lower slots are cleared.
  - conflict=1 for that cycle's captured bundle; conflict returns to 0 on the next unstalled capture without a conflict.
- Writeback outputs:
  - wb_we/wb_rd/wb_data come directly from stage DEPTH-1 registers.
  - Latency from capture edge to wb_we assertion: DEPTH-1 cycles after the capturing edge, i.e. visible from the DEPTH-th edge.
  - wb_we is only asserted for valid entries; wb_data is 0 for invalid entries.
- Forwarding (combinational over stage registers):
  - Priority: youngest stage first (stage 0 highest), then highest slot index within a stage.
  - fwd_addr == 0 always gives hit=0, data=0.
  - Lookup includes stage DEPTH-1, so values written this cycle are also forwarded. This covers register-file write-then-read ordering.
- Values are only transported; no arithmetic on results.
- Reset mid-operation: all in-flight entries are discarded immediately; no partial writes occur after rst deasserts.

Optional Feature:
- Macro WB_CONFLICT_CNT_EN.
- When defined:
  - Adds output conflict_cnt (16 bits), counting captured conflicts.
  - The counter saturates at 16'hFFFF and resets to 0.
  - It increments only on unstalled capture cycles with a conflict. A bundle with several conflicting pairs counts once.
- When not defined: the port and counter are absent; conflict pulse behaviour is unchanged.

Test Plan:
- Basic pipeline (DEPTH=2):
  - Stimulus: slot1 valid, rd=5, res=32'hDEAD_BEEF, captured at edge 0.
  - Required response: wb_we[1]=1, rd=5, data=DEAD_BEEF after edge 1 for exactly one cycle; fwd_addr=5 hits before and during that cycle.
- Stall hold:
  - Stimulus: bundle rd=3/7 in stage 0, then stall=1 for 3 cycles.
  - Required response: stage contents and wb outputs unchanged; after stall drops, writes appear exactly one edge later.
- Flush and x0:
  - Stimulus: flush=1 with all 4 slots valid (rd=1..4); separately slot0 rd=0 valid.
  - Required response: wb_we stays 0 in both cases; fwd_hit=0 for addresses 1..4 and 0.
- Same-bundle conflict:
  - Stimulus: slot0 and slot2 both rd=9, res=11 and 22.
  - Required response: only wb_we[2]=1 with data 22; conflict=1 for one cycle; conflict_cnt=1 when enabled.
- Forward priority:
  - Stimulus: stage 1 holds rd=6 → 100; stage 0 holds rd=6 → 200 (slot0) and 300 (slot3).
  - Required response: fwd_data=300, fwd_hit=1.
- Async reset:
  - Stimulus: assert rst between edges with stages full.
  - Required response: wb_we and fwd_hit go to 0 immediately; first capture after release behaves normally; conflict_cnt=0.
